// File: rtl/reset_sequencer.sv
// Staged reset release for the SoC: bus, then CPU, then peripherals,
// plus a software soft reset with a one-cycle acknowledge.
//
// Ports:
//   system_clock   - sole clock, rising edge
//   reset          - synchronous active-high master reset
//   soft_reset_req - level soft-reset request, honoured only once running
//   soft_reset_ack - one-cycle pulse when a soft reset is accepted
//   bus_reset      - active-high bus-domain reset
//   cpu_reset      - active-high CPU-domain reset
//   periph_reset   - active-high peripheral-domain reset
//   reset_done     - high once every domain is released
//   seq_busy       - registered inverse of reset_done

module reset_sequencer #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned STAGE_GAP   = 2,
    parameter int unsigned SOFT_HOLD   = 8
) (
    input  logic system_clock,
    input  logic reset,
    input  logic soft_reset_req,
    output logic soft_reset_ack,
    output logic bus_reset,
    output logic cpu_reset,
    output logic periph_reset,
    output logic reset_done,
    output logic seq_busy
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255 ||
        STAGE_GAP < 1 || STAGE_GAP > 255 ||
        SOFT_HOLD < 1 || SOFT_HOLD > 255) begin : g_bad_params
        $error("reset_sequencer: parameters must be in 1..255");
    end

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_BUS,
        ST_CPU,
        ST_PERIPH,
        ST_RUN,
        ST_SOFT
    } state_t;

    // Terminal counts: a stage lasting N edges ends when cnt reaches N-1.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LAST  = 8'(STAGE_GAP - 1);
    localparam logic [7:0] SOFT_LAST = 8'(SOFT_HOLD - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       bus_q, bus_d;
    logic       cpu_q, cpu_d;
    logic       periph_q, periph_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       ack_q, ack_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bus_d    = bus_q;
        cpu_d    = cpu_q;
        periph_d = periph_q;
        done_d   = done_q;
        busy_d   = busy_q;
        // The acknowledge is a pulse: it only survives the accepting edge.
        ack_d    = 1'b0;

        case (state_q)
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = 8'd0;
                    bus_d   = 1'b0;
                    state_d = ST_BUS;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_BUS: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 8'd0;
                    cpu_d   = 1'b0;
                    state_d = ST_CPU;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_CPU: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d    = 8'd0;
                    periph_d = 1'b0;
                    state_d  = ST_PERIPH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_PERIPH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (soft_reset_req) begin
                    bus_d    = 1'b1;
                    cpu_d    = 1'b1;
                    periph_d = 1'b1;
                    done_d   = 1'b0;
                    busy_d   = 1'b1;
                    ack_d    = 1'b1;
                    cnt_d    = 8'd0;
                    state_d  = ST_SOFT;
                end
            end
            ST_SOFT: begin
                // Domains stay asserted here; release resumes from ST_HOLD.
                if (cnt_q == SOFT_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                bus_d    = 1'b1;
                cpu_d    = 1'b1;
                periph_d = 1'b1;
                done_d   = 1'b0;
                busy_d   = 1'b1;
                cnt_d    = 8'd0;
                state_d  = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge system_clock) begin
        if (reset) begin
            state_q  <= ST_HOLD;
            cnt_q    <= 8'd0;
            bus_q    <= 1'b1;
            cpu_q    <= 1'b1;
            periph_q <= 1'b1;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bus_q    <= bus_d;
            cpu_q    <= cpu_d;
            periph_q <= periph_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
        end
    end

    assign soft_reset_ack = ack_q;
    assign bus_reset      = bus_q;
    assign cpu_reset      = cpu_q;
    assign periph_reset   = periph_q;
    assign reset_done     = done_q;
    assign seq_busy       = busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default and minimum parameter instances
// share one stimulus stream; an edge-count model checks every cycle.

module tb_reset_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic req;

    logic [1:0] ack_w, bus_w, cpu_w, per_w, done_w, busy_w;

    always #5 clk = ~clk;

    reset_sequencer u_def (
        .system_clock   (clk),
        .reset          (rst),
        .soft_reset_req (req),
        .soft_reset_ack (ack_w[0]),
        .bus_reset      (bus_w[0]),
        .cpu_reset      (cpu_w[0]),
        .periph_reset   (per_w[0]),
        .reset_done     (done_w[0]),
        .seq_busy       (busy_w[0])
    );

    reset_sequencer #(
        .HOLD_CYCLES (1),
        .STAGE_GAP   (1),
        .SOFT_HOLD   (1)
    ) u_min (
        .system_clock   (clk),
        .reset          (rst),
        .soft_reset_req (req),
        .soft_reset_ack (ack_w[1]),
        .bus_reset      (bus_w[1]),
        .cpu_reset      (cpu_w[1]),
        .periph_reset   (per_w[1]),
        .reset_done     (done_w[1]),
        .seq_busy       (busy_w[1])
    );

    int tests = 0;
    int fails = 0;

    // Model: n = edges since the sequence (re)started, off = extra edges
    // a soft reset adds in front of the normal release schedule.
    int hp [2] = '{4, 1};
    int gp [2] = '{2, 1};
    int sp [2] = '{8, 1};
    int n [2];
    int off [2];
    bit acc [2];
    bit mvalid = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                n[i]   = -1;
                off[i] = 0;
                acc[i] = 1'b0;
            end else begin
                acc[i] = (n[i] >= hp[i] + 2 * gp[i] + off[i]) && req;
                if (acc[i]) begin
                    n[i]   = 0;
                    off[i] = sp[i] + 1;
                end else begin
                    n[i] = n[i] + 1;
                end
            end
        end
        if (rst) mvalid = 1'b1;
    end

    function automatic logic [5:0] model_exp(int i);
        logic b, c, p, d;
        b = !(n[i] >= hp[i] - 1 + off[i]);
        c = !(n[i] >= hp[i] - 1 + gp[i] + off[i]);
        p = !(n[i] >= hp[i] - 1 + 2 * gp[i] + off[i]);
        d = (n[i] >= hp[i] + 2 * gp[i] + off[i]);
        return {acc[i], b, c, p, d, !d};
    endfunction

    function automatic logic [5:0] dut_got(int i);
        return {ack_w[i], bus_w[i], cpu_w[i], per_w[i], done_w[i], busy_w[i]};
    endfunction

    always @(negedge clk) begin
        if (mvalid) begin
            for (int i = 0; i < 2; i++) begin
                logic [5:0] g, e;
                g = dut_got(i);
                e = model_exp(i);
                tests++;
                if (g !== e) begin
                    fails++;
                    $display("FAIL model dut=%0d n=%0d got=%b exp=%b",
                             i, n[i], g, e);
                end
            end
        end
    end

    // Literal check on {ack, bus, cpu, periph, done}.
    task automatic lit(string nm, int i, logic [4:0] e);
        logic [4:0] g;
        g = {ack_w[i], bus_w[i], cpu_w[i], per_w[i], done_w[i]};
        tests++;
        if (g !== e) begin
            fails++;
            $display("FAIL %s dut=%0d got=%b exp=%b", nm, i, g, e);
        end
    endtask

    task automatic step(logic r, logic q);
        rst = r;
        req = q;
        @(posedge clk);
        #1;
    endtask

    logic ack_seen;

    initial begin
        rst = 1'b1;
        req = 1'b0;

        // Power-on reset; req held during the release sequence.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
        lit("por_def", 0, 5'b0_1110);
        lit("por_min", 1, 5'b0_1110);
        tests++;
        if (busy_w !== 2'b11) begin
            fails++;
            $display("FAIL por_busy got=%b exp=11", busy_w);
        end

        ack_seen = 1'b0;
        for (int e = 0; e <= 10; e++) begin
            step(1'b0, e <= 6);
            ack_seen |= ack_w[0];
            case (e)
                0: lit("min_e0", 1, 5'b0_0110);
                1: lit("min_e1", 1, 5'b0_0010);
                2: begin
                    lit("def_e2", 0, 5'b0_1110);
                    lit("min_e2", 1, 5'b0_0000);
                end
                3: begin
                    lit("def_e3", 0, 5'b0_0110);
                    lit("min_e3", 1, 5'b0_0001);
                end
                4: begin
                    lit("def_e4", 0, 5'b0_0110);
                    lit("min_s0", 1, 5'b1_1110);
                end
                5: begin
                    lit("def_e5", 0, 5'b0_0010);
                    lit("min_s1", 1, 5'b0_1110);
                end
                6: lit("min_s2", 1, 5'b0_0110);
                7: lit("def_e7", 0, 5'b0_0000);
                8: lit("def_e8", 0, 5'b0_0001);
                9: lit("min_s5", 1, 5'b0_0001);
                default: ;
            endcase
        end
        tests++;
        if (ack_seen !== 1'b0) begin
            fails++;
            $display("FAIL req_outside_run got=%b exp=0", ack_seen);
        end

        // Reset reasserted mid-sequence, then a full restart.
        for (int k = 0; k < 2; k++) step(1'b1, 1'b0);
        for (int e = 0; e < 4; e++) step(1'b0, 1'b0);
        lit("mid_e3", 0, 5'b0_0110);
        step(1'b1, 1'b0);
        lit("mid_rst", 0, 5'b0_1110);
        for (int e = 0; e <= 10; e++) begin
            step(1'b0, 1'b0);
            case (e)
                2: lit("re_e2", 0, 5'b0_1110);
                3: lit("re_e3", 0, 5'b0_0110);
                8: lit("re_e8", 0, 5'b0_0001);
                default: ;
            endcase
        end

        // Soft reset from run, single-cycle request.
        step(1'b0, 1'b1);
        lit("soft_s0", 0, 5'b1_1110);
        for (int s = 1; s <= 20; s++) begin
            step(1'b0, 1'b0);
            case (s)
                1:  lit("soft_s1", 0, 5'b0_1110);
                11: lit("soft_s11", 0, 5'b0_1110);
                12: lit("soft_s12", 0, 5'b0_0110);
                14: lit("soft_s14", 0, 5'b0_0010);
                15: lit("soft_s15", 0, 5'b0_0010);
                16: lit("soft_s16", 0, 5'b0_0000);
                17: lit("soft_s17", 0, 5'b0_0001);
                default: ;
            endcase
        end

        // Reset and req at the same edge; req held through release.
        step(1'b1, 1'b1);
        lit("sim_def", 0, 5'b0_1110);
        lit("sim_min", 1, 5'b0_1110);
        for (int e = 0; e <= 9; e++) begin
            step(1'b0, 1'b1);
            case (e)
                7: lit("lvl_e7", 0, 5'b0_0000);
                8: lit("lvl_e8", 0, 5'b0_0001);
                9: lit("lvl_e9", 0, 5'b1_1110);
                default: ;
            endcase
        end
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0);
        lit("final_def", 0, 5'b0_0001);
        lit("final_min", 1, 5'b0_0001);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
